// File: rtl/alu_pkg.sv
// ALU control package: op codes, decoder classes, funct7 values, MDU state.
package alu_pkg;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SLT   = 4'b0101;
  localparam logic [3:0] ALU_SLTU  = 4'b0110;
  localparam logic [3:0] ALU_SLL   = 4'b0111;
  localparam logic [3:0] ALU_SRL   = 4'b1000;
  localparam logic [3:0] ALU_SRA   = 4'b1001;
  localparam logic [3:0] ALU_PASSB = 4'b1010;

  localparam logic [1:0] ALU_OP_ADD  = 2'b00;
  localparam logic [1:0] ALU_OP_SUB  = 2'b01;
  localparam logic [1:0] ALU_OP_RI   = 2'b10;
  localparam logic [1:0] ALU_OP_PASS = 2'b11;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } mdu_state_t;

  // MUL/MULH/MULHSU/DIV/REM treat operand a as signed
  function automatic logic op_signed_a(input logic [2:0] f3);
    return (~f3[2] & ~(f3[1] & f3[0])) | (f3[2] & ~f3[0]);
  endfunction

  // MUL/MULH/DIV/REM treat operand b as signed
  function automatic logic op_signed_b(input logic [2:0] f3);
    return (~f3[2] & ~f3[1]) | (f3[2] & ~f3[0]);
  endfunction

endpackage

// File: rtl/mdu_seq.sv
// Sequential multiply/divide unit: shift-add multiplier and restoring
// divider, one bit per cycle on operand magnitudes.
module mdu_seq
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  mdu_state_t state;
  mdu_state_t state_n;

  logic [CW-1:0]     cnt;
  logic [2:0]        f3;
  logic [XLEN-1:0]   hi;
  logic [XLEN-1:0]   lo;
  logic [XLEN-1:0]   opnd;
  logic [XLEN-1:0]   a_raw;
  logic              neg_q;
  logic              neg_r;

  logic              sa;
  logic              sb;
  logic [XLEN-1:0]   abs_a;
  logic [XLEN-1:0]   abs_b;
  logic              busy;
  logic              divz;
  logic              fin;
  logic [XLEN:0]     sum;
  logic [XLEN:0]     shifted;
  logic [XLEN+1:0]   diff;
  logic [XLEN-1:0]   hi_n;
  logic [XLEN-1:0]   lo_n;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   res_fin;

  assign sa    = op_signed_a(funct3) & a[XLEN-1];
  assign sb    = op_signed_b(funct3) & b[XLEN-1];
  assign abs_a = sa ? -a : a;
  assign abs_b = sb ? -b : b;

  assign busy = (state == S_MUL) || (state == S_DIV);
  assign divz = (state == S_DIV) && (opnd == '0);
  assign fin  = (busy && (cnt == CW'(XLEN - 1))) || divz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (start) state_n = funct3[2] ? S_DIV : S_MUL;
      S_MUL:   if (fin) state_n = S_DONE;
      S_DIV:   if (fin) state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    done = (state == S_DONE);
  end

  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    shifted = {hi, lo[XLEN-1]};
    diff    = {1'b0, shifted} - {2'b00, opnd};
    if (state == S_DIV) begin
      hi_n = diff[XLEN+1] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
      lo_n = {lo[XLEN-2:0], ~diff[XLEN+1]};
    end else begin
      hi_n = sum[XLEN:1];
      lo_n = {sum[0], lo[XLEN-1:1]};
    end
    prod = neg_q ? -{hi_n, lo_n} : {hi_n, lo_n};
    quo  = neg_q ? -lo_n : lo_n;
    rem  = neg_r ? -hi_n : hi_n;
    if (divz)
      res_fin = f3[1] ? a_raw : '1;
    else if (!f3[2])
      res_fin = (f3 == 3'b000) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    else
      res_fin = f3[1] ? rem : quo;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      f3     <= '0;
      hi     <= '0;
      lo     <= '0;
      opnd   <= '0;
      a_raw  <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      result <= '0;
    end else begin
      if ((state == S_IDLE) && start) begin
        cnt   <= '0;
        f3    <= funct3;
        hi    <= '0;
        lo    <= funct3[2] ? abs_a : abs_b;
        opnd  <= funct3[2] ? abs_b : abs_a;
        a_raw <= a;
        neg_q <= sa ^ sb;
        neg_r <= sa;
      end else if (busy) begin
        hi  <= hi_n;
        lo  <= lo_n;
        cnt <= cnt + CW'(1);
      end
      if (fin) result <= res_fin;
    end
  end

endmodule

// File: rtl/alu_ctrl_mdu.sv
// ALU control decoder with optional sequential M-extension unit,
// enabled by defining ALU_CTRL_MDU_EN.
module alu_ctrl_mdu
  import alu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  input  logic [1:0]        i_alu_op,
  input  logic [2:0]        i_funct3,
  input  logic [6:0]        i_funct7,
  input  logic              i_op,
  input  logic [XLEN-1:0]   i_src_a,
  input  logic [XLEN-1:0]   i_src_b,
  output logic [CTRL_W-1:0] o_alu_ctrl,
  output logic              o_illegal,
  output logic              o_stall,
  output logic              o_mdu_done,
  output logic [XLEN-1:0]   o_mdu_result
);

`ifdef ALU_CTRL_MDU_EN
  localparam bit MDU_EN = 1'b1;
`else
  localparam bit MDU_EN = 1'b0;
`endif

  logic [3:0] ctrl;
  logic       illegal;
  logic       is_m;
  logic       f7z;
  logic       f7a;
  logic       r_ok;

  assign is_m = i_op & (i_funct7 == F7_MULDIV);
  assign f7z  = (i_funct7 == F7_BASE);
  assign f7a  = (i_funct7 == F7_ALT);
  assign r_ok = ~i_op | f7z;

  always_comb begin
    ctrl    = ALU_ADD;
    illegal = 1'b0;
    unique case (1'b1)
      (i_alu_op == ALU_OP_ADD):  ctrl = ALU_ADD;
      (i_alu_op == ALU_OP_SUB):  ctrl = ALU_SUB;
      (i_alu_op == ALU_OP_PASS): ctrl = ALU_PASSB;
      (i_alu_op == ALU_OP_RI): begin
        if (is_m) begin
          illegal = ~MDU_EN;
        end else begin
          unique case (i_funct3)
            3'b000: begin
              if (!i_op || f7z) ctrl = ALU_ADD;
              else if (f7a)     ctrl = ALU_SUB;
              else              illegal = 1'b1;
            end
            3'b001: if (f7z) ctrl = ALU_SLL; else illegal = 1'b1;
            3'b010: if (r_ok) ctrl = ALU_SLT; else illegal = 1'b1;
            3'b011: if (r_ok) ctrl = ALU_SLTU; else illegal = 1'b1;
            3'b100: if (r_ok) ctrl = ALU_XOR; else illegal = 1'b1;
            3'b101: begin
              if (f7z)      ctrl = ALU_SRL;
              else if (f7a) ctrl = ALU_SRA;
              else          illegal = 1'b1;
            end
            3'b110: if (r_ok) ctrl = ALU_OR; else illegal = 1'b1;
            3'b111: if (r_ok) ctrl = ALU_AND; else illegal = 1'b1;
            default: illegal = 1'b1;
          endcase
        end
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) ctrl = ALU_ADD;
  end

  assign o_alu_ctrl = CTRL_W'(ctrl);
  assign o_illegal  = illegal;

`ifdef ALU_CTRL_MDU_EN
  logic mop;

  assign mop = i_valid & (i_alu_op == ALU_OP_RI) & is_m;

  mdu_seq #(
    .XLEN(XLEN)
  ) u_mdu (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .start  (mop),
    .funct3 (i_funct3),
    .a      (i_src_a),
    .b      (i_src_b),
    .done   (o_mdu_done),
    .result (o_mdu_result)
  );

  assign o_stall = mop & ~o_mdu_done;
`else
  logic unused_in;

  assign unused_in    = ^{i_clk, i_rst_n, i_valid, i_src_a, i_src_b};
  assign o_stall      = 1'b0;
  assign o_mdu_done   = 1'b0;
  assign o_mdu_result = '0;
`endif

endmodule
